// File: rtl/prbs_check_if.sv
// rtl/prbs_check_if.sv - serial PRBS checker stream and status bundle
interface prbs_check_if;
  logic        din;
  logic        din_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_count;

  modport master (
    output din,
    output din_valid,
    output clr_cnt,
    input  locked,
    input  err,
    input  err_count
  );

  modport slave (
    input  din,
    input  din_valid,
    input  clr_cnt,
    output locked,
    output err,
    output err_count
  );
endinterface

// File: rtl/prbs_check.sv
// rtl/prbs_check.sv - PRBS-3/4/5 checker with fill/hunt/locked synchronisation
// Optional saturating error counter built only with PRBS_CHECK_ERRCNT_EN defined.
module prbs_check #(
  parameter int N        = 3,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  prbs_check_if.slave bus
);
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TGT  = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_TGT  = 8'(LOSS_CNT);
  localparam logic [2:0] FILL_LAST = 3'(N - 1);

  state_t     r_state, w_state_nxt;
  logic [1:N] r_s, w_s_nxt;
  logic [2:0] r_fill, w_fill_nxt;
  logic [7:0] r_match, w_match_nxt;
  logic [7:0] r_miss, w_miss_nxt;
  logic       r_err, w_err_nxt;
  logic       w_p;
  logic       w_hit;
  logic       w_s_zero;

  generate
    if (N == 3) begin : g_p3
      assign w_p = r_s[3] ^ r_s[2];
    end else if (N == 4) begin : g_p4
      assign w_p = r_s[3] ^ r_s[4];
    end else begin : g_p5
      assign w_p = r_s[5] ^ r_s[3];
    end
  endgenerate

  assign w_hit    = (bus.din == w_p);
  assign w_s_zero = (r_s == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    w_miss_nxt  = r_miss;
    w_err_nxt   = 1'b0;
    if (bus.din_valid) begin
      unique case (r_state)
        FILL: begin
          w_s_nxt = {bus.din, r_s[1:N-1]};
          if (r_fill == FILL_LAST) begin
            w_fill_nxt  = '0;
            w_match_nxt = '0;
            w_state_nxt = HUNT;
          end else begin
            w_fill_nxt = r_fill + 3'd1;
          end
        end
        HUNT: begin
          w_s_nxt = {bus.din, r_s[1:N-1]};
          // an all-zero shadow predicts 0 forever, so it must never count
          if (w_hit && !w_s_zero) begin
            if (r_match + 8'd1 == LOCK_TGT) begin
              w_match_nxt = '0;
              w_miss_nxt  = '0;
              w_state_nxt = LOCKED;
            end else begin
              w_match_nxt = r_match + 8'd1;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          // free-run on the prediction so a bad bit never pollutes the shadow
          w_s_nxt = {w_p, r_s[1:N-1]};
          if (w_hit) begin
            w_miss_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
            if (r_miss + 8'd1 == LOSS_TGT) begin
              w_miss_nxt  = '0;
              w_match_nxt = '0;
              w_fill_nxt  = '0;
              w_state_nxt = FILL;
            end else begin
              w_miss_nxt = r_miss + 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_s     <= '0;
      r_fill  <= '0;
      r_match <= '0;
      r_miss  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_match_nxt;
      r_miss  <= w_miss_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.locked = (r_state == LOCKED);
  assign bus.err    = r_err;

`ifdef PRBS_CHECK_ERRCNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (bus.clr_cnt) begin
      r_err_count <= '0;
    end else if (r_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.err_count = r_err_count;
`else
  // no counter: clr_cnt has nothing to act on and the count reads as zero
  assign bus.err_count = {16{bus.clr_cnt & 1'b0}};
`endif

endmodule

// File: tb/tb_prbs_check.sv
// tb/tb_prbs_check.sv - directed bench for prbs_check with a behavioural reference model
module tb_prbs_check;
  localparam int N        = 3;
  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;
`ifdef PRBS_CHECK_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif
  localparam int TAP_A = (N == 3) ? 2 : 3;
  localparam int TAP_B = (N == 3) ? 3 : ((N == 4) ? 4 : 5);

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  prbs_check_if bus ();
  prbs_check #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef PRBS_CHECK_ERRCNT_EN
  prbs_check_if bus2 ();
  prbs_check #(.N(3), .LOCK_CNT(8), .LOSS_CNT(255)) dut_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: mode 0 = fill, 1 = hunt, 2 = locked
  int          m_mode, m_nfill, m_match, m_miss;
  bit          m_hist[$];
  logic        exp_locked, exp_err;
  logic [15:0] exp_cnt;
  logic [6:0]  pat = 7'b1011100;
  int          sidx = 0;

  function automatic bit gen(input int i);
    return pat[6 - (i % 7)];
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_nfill = 0; m_match = 0; m_miss = 0;
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
    exp_locked = 1'b0; exp_err = 1'b0; exp_cnt = 16'd0;
  endfunction

  function automatic void model_step(input bit d, input bit v, input bit c);
    bit p;
    bit zero;
    if (ERRCNT) begin
      if (c) exp_cnt = 16'd0;
      else if (exp_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    exp_err = 1'b0;
    if (v) begin
      p = m_hist[TAP_A-1] ^ m_hist[TAP_B-1];
      zero = 1'b1;
      for (int i = 0; i < N; i++) if (m_hist[i]) zero = 1'b0;
      if (m_mode == 2) m_hist.push_front(p);
      else m_hist.push_front(d);
      void'(m_hist.pop_back());
      if (m_mode == 0) begin
        m_nfill++;
        if (m_nfill == N) begin m_mode = 1; m_match = 0; m_nfill = 0; end
      end else if (m_mode == 1) begin
        if (d == p && !zero) m_match++;
        else m_match = 0;
        if (m_match == LOCK_CNT) begin m_mode = 2; m_miss = 0; m_match = 0; end
      end else begin
        if (d != p) begin
          exp_err = 1'b1;
          m_miss++;
          if (m_miss == LOSS_CNT) begin m_mode = 0; m_miss = 0; m_match = 0; m_nfill = 0; end
        end else begin
          m_miss = 0;
        end
      end
    end
    exp_locked = (m_mode == 2);
  endfunction

  always @(negedge clk) begin
    n_cmp++;
    if (bus.locked !== exp_locked || bus.err !== exp_err || bus.err_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t locked=%b/%b err=%b/%b err_count=%0h/%0h (got/required)",
               $time, bus.locked, exp_locked, bus.err, exp_err, bus.err_count, exp_cnt);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step(input bit d, input bit v, input bit c);
    @(negedge clk); #1;
    bus.din = d; bus.din_valid = v; bus.clr_cnt = c;
    model_step(d, v, c);
    @(posedge clk); #1;
  endtask

  task automatic send_clean();
    step(gen(sidx), 1'b1, 1'b0);
    sidx++;
  endtask

  task automatic send_bad();
    step(!gen(sidx), 1'b1, 1'b0);
    sidx++;
  endtask

`ifdef PRBS_CHECK_ERRCNT_EN
  task automatic step2(input bit d, input bit c);
    @(negedge clk); #1;
    bus2.din = d; bus2.din_valid = 1'b1; bus2.clr_cnt = c;
    @(posedge clk); #1;
  endtask

  task automatic run_saturation();
    int s2;
    int nerr;
    int run;
    s2 = 0; nerr = 0; run = 0;
    for (int i = 0; i < 11; i++) begin step2(gen(s2), 1'b0); s2++; end
    chk("sat_lock", {15'd0, bus2.locked}, 16'd1);
    while (nerr < 65536) begin
      if (run == 254) begin
        step2(gen(s2), 1'b0); run = 0;
      end else begin
        step2(!gen(s2), 1'b0); run++; nerr++;
      end
      s2++;
    end
    step2(gen(s2), 1'b0); s2++;
    chk("sat_count", bus2.err_count, 16'hFFFF);
    chk("sat_locked", {15'd0, bus2.locked}, 16'd1);
    step2(!gen(s2), 1'b0); s2++;
    chk("sat_err_pulse", {15'd0, bus2.err}, 16'd1);
    step2(gen(s2), 1'b1); s2++;
    chk("clr_over_inc", bus2.err_count, 16'd0);
    step2(gen(s2), 1'b0); s2++;
    chk("clr_stays", bus2.err_count, 16'd0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr_cnt = 1'b0;
`ifdef PRBS_CHECK_ERRCNT_EN
    bus2.din = 1'b0; bus2.din_valid = 1'b0; bus2.clr_cnt = 1'b0;
`endif
    model_reset();
    #3;
    chk("reset_locked", {15'd0, bus.locked}, 16'd0);
    chk("reset_err", {15'd0, bus.err}, 16'd0);
    chk("reset_count", bus.err_count, 16'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // clean lock after N + LOCK_CNT valid bits
    for (int i = 1; i <= 11; i++) begin
      send_clean();
      if (i == 10) chk("lock_not_yet", {15'd0, bus.locked}, 16'd0);
      if (i == 11) chk("lock_at_11", {15'd0, bus.locked}, 16'd1);
    end
    for (int i = 0; i < 14; i++) send_clean();

    // single error
    send_bad();
    chk("single_err_pulse", {15'd0, bus.err}, 16'd1);
    send_clean();
    chk("single_err_gone", {15'd0, bus.err}, 16'd0);
    chk("single_locked", {15'd0, bus.locked}, 16'd1);
    chk("single_count", bus.err_count, ERRCNT ? 16'd1 : 16'd0);
    for (int i = 0; i < 5; i++) send_clean();

    // loss of lock on the LOSS_CNT-th consecutive error, then relock
    for (int i = 1; i <= 4; i++) begin
      send_bad();
      chk("loss_err_pulse", {15'd0, bus.err}, 16'd1);
      if (i == 3) chk("loss_still_locked", {15'd0, bus.locked}, 16'd1);
    end
    chk("loss_unlocked", {15'd0, bus.locked}, 16'd0);
    for (int i = 1; i <= 11; i++) begin
      send_clean();
      if (i == 10) chk("relock_not_yet", {15'd0, bus.locked}, 16'd0);
    end
    chk("relock", {15'd0, bus.locked}, 16'd1);
    chk("loss_count", bus.err_count, ERRCNT ? 16'd5 : 16'd0);

    // asynchronous reset while locked with err high
    send_bad();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_locked", {15'd0, bus.locked}, 16'd0);
    chk("async_err", {15'd0, bus.err}, 16'd0);
    chk("async_count", bus.err_count, 16'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // valid every other cycle
    begin
      int nv;
      nv = 0;
      for (int k = 0; k < 24; k++) begin
        if (k % 2 == 0) begin
          send_clean(); nv++;
          if (nv == 10) chk("gap_not_yet", {15'd0, bus.locked}, 16'd0);
          if (nv == 11) chk("gap_lock", {15'd0, bus.locked}, 16'd1);
        end else begin
          step(1'b1, 1'b0, 1'b0);
        end
      end
    end

    // stuck-at-zero stream never locks
    @(negedge clk); #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    chk("stuck0_locked", {15'd0, bus.locked}, 16'd0);
    chk("stuck0_err", {15'd0, bus.err}, 16'd0);
    step(1'b0, 1'b0, 1'b0);

`ifdef PRBS_CHECK_ERRCNT_EN
    run_saturation();
`endif
    step(1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prbs_check.md
PRBS_CHECK -- requirements
Module: prbs_check

Interface
REQ-001 Parameter N, default 3, meaning LFSR length; legal values are 3, 4 and 5.
REQ-002 Parameter LOCK_CNT, default 8, meaning consecutive matches required to lock; range 1..255.
REQ-003 Parameter LOSS_CNT, default 4, meaning consecutive mismatches that drop lock; range 1..255.
REQ-004 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 Port din, input, 1, meaning serial bit under test (generator feedback bit, i.e. new Q[1]).
REQ-007 Port din_valid, input, 1, meaning din is sampled this cycle.
REQ-008 Port clr_cnt, input, 1, meaning synchronous clear of err_count.
REQ-009 Port locked, output, 1, meaning checker is synchronised to the stream.
REQ-010 Port err, output, 1, meaning one-cycle pulse on a mismatched bit while locked.
REQ-011 Port err_count, output, 16, meaning saturating count of locked-state mismatches.

Function
REQ-012 The block SHALL hold shadow register S[1:N] and compute prediction p: N=3: S[3]^S[2]; N=4: S[3]^S[4]; N=5: S[5]^S[3].
REQ-013 Cycles with din_valid=0 SHALL change no state and SHALL hold err low.
REQ-014 States SHALL be: FILL, HUNT and LOCKED.
REQ-015 FILL: each valid bit SHALL be shifted in as S <= {din, S[1:N-1]}; after N valid bits, go to HUNT with match counter = 0.
REQ-016 HUNT: each valid bit SHALL be shifted in from din; on din==p and S not all-zero, increment the match counter; otherwise clear it.
REQ-017 HUNT: when the match counter reaches LOCK_CNT, go to LOCKED; locked SHALL rise on the same edge that registers the LOCK_CNT-th match.
REQ-018 All-zero S SHALL never count as a match, so a stuck-at-0 stream never locks.
REQ-019 LOCKED: each valid bit SHALL shift in p, not din, so a single error does not propagate into later predictions.
REQ-020 LOCKED: on din!=p, err SHALL pulse high on the next cycle only and the miss counter SHALL increment; on din==p, clear the miss counter.
REQ-021 LOCKED: when the miss counter reaches LOSS_CNT, go to FILL, clear locked and clear both counters; the LOSS_CNT-th error still pulses err.
REQ-022 err_count SHALL increment on each err pulse and saturate at 16'hFFFF.
REQ-023 clr_cnt SHALL zero err_count, taking priority over a simultaneous increment.
REQ-024 Counters SHALL be wide enough for 255 with no wrap.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously set state=FILL, S=0, all counters=0, locked=0, err=0 and err_count=0.
REQ-026 Reset asserted mid-operation SHALL discard lock immediately; after release the block resumes from FILL.
REQ-027 The first rising edge after rst_n deasserts SHALL be a normal operating edge.

Configuration
REQ-028 With macro PRBS_CHECK_ERRCNT_EN defined, err_count and clr_cnt SHALL behave per REQ-022/023.
REQ-029 Without PRBS_CHECK_ERRCNT_EN, the counter SHALL NOT be built: err_count is tied to 0, clr_cnt is ignored, and locked/err behaviour is unchanged.

Verification
REQ-030 Clean lock: N=3, LOCK_CNT=8, stream 1011100 repeated, valid every cycle -> locked rises after 3+8 valid bits; err never pulses.
REQ-031 Single error: while locked, invert one bit -> exactly one err pulse one cycle later; err_count=1; locked stays high; the following bits match.
REQ-032 Loss of lock: LOSS_CNT=4, invert 4 consecutive bits -> 4 err pulses, locked falls with the 4th, then relock after N+LOCK_CNT clean bits.
REQ-033 Stuck zero: din=0 for 100 valid cycles -> locked stays 0 and err stays 0.
REQ-034 Gaps and reset: din_valid toggling 1/0 -> lock occurs after 11 valid bits; rst_n pulsed low while locked -> all outputs 0 asynchronously.
REQ-035 Saturation and clear: force 65536 errors (with LOSS_CNT=255, periodic relock) -> err_count=16'hFFFF; clr_cnt coincident with err -> err_count=0.
